// File: rtl/fifo_read_checker.sv
// fifo_read_checker: drains a BURST_LEN-word burst from a FIFO and checks each word against an
// incrementing pattern starting at SEED. Define FIFO_READ_CHECKER_CAPTURE_EN for first-mismatch capture.
module fifo_read_checker #(
    parameter int unsigned    W         = 8,
    parameter int unsigned    BURST_LEN = 16,
    parameter logic [W-1:0]   SEED      = {W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_read,
    input  logic              empty,
    input  logic [W-1:0]      dout,
    output logic              rd_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       err_count,
    output logic [15:0]       rx_count
`ifdef FIFO_READ_CHECKER_CAPTURE_EN
    ,
    output logic [15:0]       first_err_idx,
    output logic [W-1:0]      first_err_data
`endif
);

    localparam logic [15:0] BURST_LEN_C = 16'(BURST_LEN);
    localparam logic [15:0] LAST_IDX_C  = 16'(BURST_LEN - 1);
    localparam logic [15:0] CNT_MAX_C   = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [15:0]    issued_q, issued_d;
    logic           vld_q, vld_d;
    logic [W-1:0]   expected_q, expected_d;
    logic [15:0]    rx_count_q, rx_count_d;
    logic [15:0]    err_count_q, err_count_d;
    logic           error_q, error_d;
`ifdef FIFO_READ_CHECKER_CAPTURE_EN
    logic [15:0]    first_idx_q, first_idx_d;
    logic [W-1:0]   first_data_q, first_data_d;
`endif

    logic           rd_en_s;
    logic           start_ok_s;
    logic           mismatch_s;

    // Next-state, read strobe and check-pipeline updates.
    always_comb begin
        state_d     = state_q;
        issued_d    = issued_q;
        expected_d  = expected_q;
        rx_count_d  = rx_count_q;
        err_count_d = err_count_q;
        error_d     = error_q;
`ifdef FIFO_READ_CHECKER_CAPTURE_EN
        first_idx_d  = first_idx_q;
        first_data_d = first_data_q;
`endif
        rd_en_s     = 1'b0;
        start_ok_s  = 1'b0;
        mismatch_s  = vld_q && (dout != expected_q);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_read) begin
                    start_ok_s = 1'b1;
                    state_d    = ST_READ;
                end else begin
                    state_d    = state_q;
                end
            end
            ST_READ: begin
                rd_en_s = !empty && (issued_q < BURST_LEN_C);
                if (rd_en_s) begin
                    issued_d = issued_q + 16'd1;
                    if (issued_q == LAST_IDX_C) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_FLUSH: begin
                if (rx_count_q == BURST_LEN_C) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        vld_d = rd_en_s;

        // The pattern always advances, so a dropped or extra word keeps failing for the rest of the run.
        if (vld_q) begin
            rx_count_d = rx_count_q + 16'd1;
            expected_d = expected_q + W'(1);
            if (mismatch_s) begin
                error_d = 1'b1;
                if (err_count_q != CNT_MAX_C) begin
                    err_count_d = err_count_q + 16'd1;
                end else begin
                    err_count_d = err_count_q;
                end
`ifdef FIFO_READ_CHECKER_CAPTURE_EN
                if (!error_q) begin
                    first_idx_d  = rx_count_q;
                    first_data_d = dout;
                end else begin
                    first_idx_d  = first_idx_q;
                    first_data_d = first_data_q;
                end
`endif
            end else begin
                error_d = error_q;
            end
        end else begin
            rx_count_d = rx_count_q;
        end

        if (start_ok_s) begin
            issued_d    = 16'd0;
            rx_count_d  = 16'd0;
            err_count_d = 16'd0;
            error_d     = 1'b0;
            expected_d  = SEED;
`ifdef FIFO_READ_CHECKER_CAPTURE_EN
            first_idx_d  = 16'd0;
            first_data_d = {W{1'b0}};
`endif
        end else begin
            issued_d    = issued_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            issued_q    <= 16'd0;
            vld_q       <= 1'b0;
            expected_q  <= SEED;
            rx_count_q  <= 16'd0;
            err_count_q <= 16'd0;
            error_q     <= 1'b0;
`ifdef FIFO_READ_CHECKER_CAPTURE_EN
            first_idx_q  <= 16'd0;
            first_data_q <= {W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            vld_q       <= vld_d;
            expected_q  <= expected_d;
            rx_count_q  <= rx_count_d;
            err_count_q <= err_count_d;
            error_q     <= error_d;
`ifdef FIFO_READ_CHECKER_CAPTURE_EN
            first_idx_q  <= first_idx_d;
            first_data_q <= first_data_d;
`endif
        end
    end

    // rd_en must see empty in the same cycle, so it stays combinational.
    assign rd_en     = rd_en_s;
    assign busy      = (state_q == ST_READ) || (state_q == ST_FLUSH);
    assign done      = (state_q == ST_DONE);
    assign error     = error_q;
    assign err_count = err_count_q;
    assign rx_count  = rx_count_q;
`ifdef FIFO_READ_CHECKER_CAPTURE_EN
    assign first_err_idx  = first_idx_q;
    assign first_err_data = first_data_q;
`endif

endmodule

// File: tb/tb_fifo_read_checker.sv
// Bench for fifo_read_checker: three instances (16/seed 0, 16/seed F8, 1/seed 0) against a run-level model.
module tb_fifo_read_checker;
    localparam int NDUT  = 3;
    localparam int LIMIT = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_read;
    logic        empty;
    logic [7:0]  dout_v  [NDUT];
    logic        rd_en_v [NDUT];
    logic        busy_v  [NDUT];
    logic        done_v  [NDUT];
    logic        error_v [NDUT];
    logic [15:0] errc_v  [NDUT];
    logic [15:0] rxc_v   [NDUT];
`ifdef FIFO_READ_CHECKER_CAPTURE_EN
    logic [15:0] fidx_v  [NDUT];
    logic [7:0]  fdat_v  [NDUT];
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int rd_cnt_a = 0;
    int done_cyc [NDUT];

    always #5 clk = ~clk;

    fifo_read_checker #(.W(8), .BURST_LEN(16), .SEED(8'h00)) dut_a (
        .clk(clk), .rst(rst), .start_read(start_read), .empty(empty), .dout(dout_v[0]),
        .rd_en(rd_en_v[0]), .busy(busy_v[0]), .done(done_v[0]), .error(error_v[0]),
        .err_count(errc_v[0]), .rx_count(rxc_v[0])
`ifdef FIFO_READ_CHECKER_CAPTURE_EN
        , .first_err_idx(fidx_v[0]), .first_err_data(fdat_v[0])
`endif
    );
    fifo_read_checker #(.W(8), .BURST_LEN(16), .SEED(8'hF8)) dut_b (
        .clk(clk), .rst(rst), .start_read(start_read), .empty(empty), .dout(dout_v[1]),
        .rd_en(rd_en_v[1]), .busy(busy_v[1]), .done(done_v[1]), .error(error_v[1]),
        .err_count(errc_v[1]), .rx_count(rxc_v[1])
`ifdef FIFO_READ_CHECKER_CAPTURE_EN
        , .first_err_idx(fidx_v[1]), .first_err_data(fdat_v[1])
`endif
    );
    fifo_read_checker #(.W(8), .BURST_LEN(1), .SEED(8'h00)) dut_c (
        .clk(clk), .rst(rst), .start_read(start_read), .empty(empty), .dout(dout_v[2]),
        .rd_en(rd_en_v[2]), .busy(busy_v[2]), .done(done_v[2]), .error(error_v[2]),
        .err_count(errc_v[2]), .rx_count(rxc_v[2])
`ifdef FIFO_READ_CHECKER_CAPTURE_EN
        , .first_err_idx(fidx_v[2]), .first_err_data(fdat_v[2])
`endif
    );

    function automatic int bl_of(input int k);
        return (k == 2) ? 1 : 16;
    endfunction

    function automatic logic [7:0] seed_of(input int k);
        return (k == 1) ? 8'hF8 : 8'h00;
    endfunction

    // FIFO stand-in: always has data, returns the next stored word the cycle after rd_en.
    logic [7:0] mem  [NDUT][256];
    logic [7:0] fptr [NDUT];
    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < NDUT; k++) begin
            if (!rst) begin
                fptr[k]   <= 8'd0;
                dout_v[k] <= 8'd0;
            end else if (rd_en_v[k]) begin
                dout_v[k] <= mem[k][fptr[k]];
                fptr[k]   <= fptr[k] + 8'd1;
            end
        end
    end

    // Run-level reference model, advanced once per clock edge by the stimulus process.
    bit         m_run    [NDUT];
    bit         m_done   [NDUT];
    bit         m_pend   [NDUT];
    int         m_issued [NDUT];
    int         m_rx     [NDUT];
    int         m_errs   [NDUT];
    int         m_ptr    [NDUT];
    int         m_fidx   [NDUT];
    logic [7:0] m_exp    [NDUT];
    logic [7:0] m_pdata  [NDUT];
    logic [7:0] m_fdata  [NDUT];

    task automatic model_clear_run(input int k);
        m_issued[k] = 0; m_rx[k] = 0; m_errs[k] = 0; m_exp[k] = seed_of(k);
        m_pend[k] = 1'b0; m_fidx[k] = 0; m_fdata[k] = 8'h00;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            model_clear_run(k);
            m_run[k] = 1'b0; m_done[k] = 1'b0; m_ptr[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit rd;
        bit fin;
        if (rst) begin
            for (int k = 0; k < NDUT; k++) begin
                rd  = m_run[k] && (m_issued[k] < bl_of(k)) && !empty;
                fin = m_run[k] && (m_rx[k] == bl_of(k));
                if (m_pend[k]) begin
                    if (m_pdata[k] != m_exp[k]) begin
                        if (m_errs[k] == 0) begin
                            m_fidx[k] = m_rx[k]; m_fdata[k] = m_pdata[k];
                        end
                        m_errs[k]++;
                    end
                    m_rx[k]++;
                    m_exp[k] = m_exp[k] + 8'd1;
                end
                m_pend[k] = rd;
                if (rd) begin
                    m_pdata[k] = mem[k][m_ptr[k] % 256];
                    m_ptr[k]++;
                    m_issued[k]++;
                end
                if (fin) begin
                    m_run[k] = 1'b0; m_done[k] = 1'b1;
                end else if (start_read && !m_run[k]) begin
                    model_clear_run(k);
                    m_run[k] = 1'b1; m_done[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NDUT; k++) begin
            chk("rd_en", k, 32'(rd_en_v[k]), 32'(m_run[k] && (m_issued[k] < bl_of(k)) && !empty));
            chk("busy", k, 32'(busy_v[k]), 32'(m_run[k]));
            chk("done", k, 32'(done_v[k]), 32'(m_done[k]));
            chk("error", k, 32'(error_v[k]), 32'(m_errs[k] > 0));
            chk("err_count", k, 32'(errc_v[k]), (m_errs[k] > 65535) ? 32'd65535 : 32'(m_errs[k]));
            chk("rx_count", k, 32'(rxc_v[k]), 32'(m_rx[k]));
`ifdef FIFO_READ_CHECKER_CAPTURE_EN
            chk("first_err_idx", k, 32'(fidx_v[k]), 32'(m_fidx[k]));
            chk("first_err_data", k, 32'(fdat_v[k]), 32'(m_fdata[k]));
`endif
        end
        if (rd_en_v[0]) rd_cnt_a++;
    endtask

    task automatic cycle_end();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic fill(input int k, input int bad_idx, input logic [7:0] bad_val, input int rnd_pct);
        logic [7:0] v;
        for (int i = 0; i < 64; i++) begin
            v = seed_of(k) + 8'(i);
            if (i == bad_idx) v = bad_val;
            if (int'($urandom_range(99)) < rnd_pct) v = v ^ 8'(1 + $urandom_range(254));
            mem[k][8'(fptr[k] + 8'(i))] = v;
        end
    endtask

    task automatic fill_clean();
        for (int k = 0; k < NDUT; k++) fill(k, -1, 8'h00, 0);
    endtask

    // Called #1 after an edge; cycle n is the edge n cycles after the one that samples start.
    task automatic do_run(input int lo, input int hi, input int pulse_at, input int rst_at, input int empty_pct);
        int n;
        n = 0;
        rd_cnt_a = 0;
        for (int k = 0; k < NDUT; k++) done_cyc[k] = -1;
        start_read = 1'b1;
        empty = 1'b0;
        cycle_end();
        start_read = 1'b0;
        while (n < LIMIT) begin
            for (int k = 0; k < NDUT; k++) if (done_v[k] && done_cyc[k] < 0) done_cyc[k] = n;
            if (n == rst_at) begin
                rst = 1'b0;
                model_reset();
                #1;
                chk("rst_rd_en", 0, 32'(rd_en_v[0]), 32'd0);
                chk("rst_busy", 0, 32'(busy_v[0]), 32'd0);
                chk("rst_rx_count", 0, 32'(rxc_v[0]), 32'd0);
                chk("rst_err_count", 0, 32'(errc_v[0]), 32'd0);
                #3 rst = 1'b1;
                @(posedge clk);
                model_edge();
                #1;
                return;
            end
            if (done_v[0] && done_v[1] && done_v[2] && n >= pulse_at) break;
            empty = ((n + 1 >= lo) && (n + 1 <= hi)) || (int'($urandom_range(99)) < empty_pct);
            start_read = (n + 1 == pulse_at);
            cycle_end();
            n++;
        end
        chk("run_timeout", 0, 32'(n < LIMIT), 32'd1);
        empty = 1'b0;
        start_read = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        start_read = 1'b0;
        empty = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare_all();
        chk("reset_done", 0, 32'(done_v[0]), 32'd0);
        chk("reset_rx_count", 0, 32'(rxc_v[0]), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        model_edge();
        #1;

        // Clean run on all three instances, including the seed-F8 wrap.
        fill_clean();
        do_run(0, -1, -1, -1, 0);
        chk("clean_done_cycle", 0, 32'(done_cyc[0]), 32'd18);
        chk("clean_rd_count", 0, 32'(rd_cnt_a), 32'd16);
        chk("clean_rx_count", 0, 32'(rxc_v[0]), 32'd16);
        chk("clean_err_count", 0, 32'(errc_v[0]), 32'd0);
        chk("clean_error", 0, 32'(error_v[0]), 32'd0);
        chk("wrap_done_cycle", 1, 32'(done_cyc[1]), 32'd18);
        chk("wrap_err_count", 1, 32'(errc_v[1]), 32'd0);
        chk("len1_done_cycle", 2, 32'(done_cyc[2]), 32'd3);
        chk("len1_rx_count", 2, 32'(rxc_v[2]), 32'd1);

        // Empty forced high for cycles 5..9.
        fill_clean();
        do_run(5, 9, -1, -1, 0);
        chk("stall_done_cycle", 0, 32'(done_cyc[0]), 32'd23);
        chk("stall_rd_count", 0, 32'(rd_cnt_a), 32'd16);
        chk("stall_err_count", 0, 32'(errc_v[0]), 32'd0);

        // Word 7 replaced by 0xAA.
        fill_clean();
        fill(0, 7, 8'hAA, 0);
        do_run(0, -1, -1, -1, 0);
        chk("bad7_error", 0, 32'(error_v[0]), 32'd1);
        chk("bad7_err_count", 0, 32'(errc_v[0]), 32'd1);
`ifdef FIFO_READ_CHECKER_CAPTURE_EN
        chk("bad7_first_idx", 0, 32'(fidx_v[0]), 32'd7);
        chk("bad7_first_data", 0, 32'(fdat_v[0]), 32'hAA);
`endif

        // Second start mid-run is ignored.
        fill_clean();
        do_run(0, -1, 2, -1, 0);
        chk("pulse_done_cycle", 0, 32'(done_cyc[0]), 32'd18);
        chk("pulse_rx_count", 0, 32'(rxc_v[0]), 32'd16);

        // Reset at cycle 6, then a fresh clean run.
        fill_clean();
        do_run(0, -1, -1, 6, 0);
        fill_clean();
        do_run(0, -1, -1, -1, 0);
        chk("post_rst_done_cycle", 0, 32'(done_cyc[0]), 32'd18);
        chk("post_rst_err_count", 0, 32'(errc_v[0]), 32'd0);

        // Randomised runs: stalls, corrupted words and stray start pulses.
        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < NDUT; k++) fill(k, -1, 8'h00, int'($urandom_range(12)));
            do_run(0, -1, ($urandom_range(1) == 1) ? int'($urandom_range(1, 20)) : -1, -1,
                   int'($urandom_range(60)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
